// File: rtl/mcp_alu_pkg.sv
// Shared encodings for the multicycle MIPS execute stage: ALUOp, funct and opcode values.
package mcp_alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [5:0] INSTR_RTYPE = 6'b000000;
    localparam logic [5:0] INSTR_LW    = 6'b100011;
    localparam logic [5:0] INSTR_SW    = 6'b101011;
    localparam logic [5:0] INSTR_BEQ   = 6'b000100;
    localparam logic [5:0] INSTR_ADDI  = 6'b001000;
    localparam logic [5:0] INSTR_J     = 6'b000010;

    // ALUOp the controller issues for the execute step of each opcode.
    function automatic logic [1:0] aluop_for_opcode(input logic [5:0] opcode);
        logic [1:0] op;
        op = ALUOP_ADD;
        case (opcode)
            INSTR_RTYPE: op = ALUOP_FUNCT;
            INSTR_BEQ:   op = ALUOP_SUB;
            INSTR_LW, INSTR_SW, INSTR_ADDI, INSTR_J: op = ALUOP_ADD;
            default:     op = ALUOP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: ALUOp/funct decode, add/sub/and/or/slt, zero flag.
module alu
    import mcp_alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [5:0]  funct_i,
    input  logic [1:0]  aluop_i,
    output logic [31:0] y_o,
    output logic        zero_o
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic        slt;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign slt  = $signed(a_i) < $signed(b_i);

    always_comb begin
        y_o = 32'd0;
        case (aluop_i)
            ALUOP_ADD: y_o = sum;
            ALUOP_SUB: y_o = diff;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: y_o = sum;
                    FUNCT_SUB: y_o = diff;
                    FUNCT_AND: y_o = a_i & b_i;
                    FUNCT_OR:  y_o = a_i | b_i;
                    FUNCT_SLT: y_o = {31'd0, slt};
                    default:   y_o = 32'd0;
                endcase
            end
            // Reserved encoding behaves as add.
            default: y_o = sum;
        endcase
    end

    assign zero_o = (y_o == 32'd0);

endmodule

// File: rtl/flopenr.sv
// Load-enabled register with asynchronous active-low reset; holds when en_i is low.
module flopenr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/flopr.sv
// Free-running register with asynchronous active-low reset; loads every rising edge.
module flopr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = d_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mcp_alu_regs.sv
// Execute-stage slice: combinational ALU, unconditional ALUOut register and an
// enabled holding register of the PC/IR kind.
module mcp_alu_regs
    import mcp_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      a_i32,
    input  logic [31:0]      b_i32,
    input  logic [5:0]       funct_i6,
    input  logic [1:0]       alt_ctrl_i2,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i32,
    output logic [31:0]      y_o32,
    output logic             zero_o,
    output logic [31:0]      alu_out_o32,
    output logic [WIDTH-1:0] q_o32
);

    alu u_alu (
        .a_i     (a_i32),
        .b_i     (b_i32),
        .funct_i (funct_i6),
        .aluop_i (alt_ctrl_i2),
        .y_o     (y_o32),
        .zero_o  (zero_o)
    );

    flopr #(
        .WIDTH (32)
    ) u_alu_out (
        .clk_i  (clk_i),
        .rst_ni (reset_i),
        .d_i    (y_o32),
        .q_o    (alu_out_o32)
    );

    flopenr #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_i  (clk_i),
        .rst_ni (reset_i),
        .en_i   (en_i),
        .d_i    (d_i32),
        .q_o    (q_o32)
    );

endmodule

// File: tb/tb_mcp_alu_regs.sv
// Bench for mcp_alu_regs: table-driven ALU vectors with an ALUOut scoreboard,
// plus hand sequences for the enabled register and asynchronous reset.
module tb_mcp_alu_regs;

    logic        clk_i;
    logic        reset_i;
    logic [31:0] a_i32;
    logic [31:0] b_i32;
    logic [5:0]  funct_i6;
    logic [1:0]  alt_ctrl_i2;
    logic        en_i;
    logic [31:0] d_i32;
    logic [31:0] y_o32;
    logic        zero_o;
    logic [31:0] alu_out_o32;
    logic [31:0] q_o32;

    int errors;
    int checks;

    logic [31:0] sb_q[$];

    typedef struct {
        logic [1:0]  alt;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_y;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[14];

    mcp_alu_regs #(
        .WIDTH (32)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .a_i32       (a_i32),
        .b_i32       (b_i32),
        .funct_i6    (funct_i6),
        .alt_ctrl_i2 (alt_ctrl_i2),
        .en_i        (en_i),
        .d_i32       (d_i32),
        .y_o32       (y_o32),
        .zero_o      (zero_o),
        .alu_out_o32 (alu_out_o32),
        .q_o32       (q_o32)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_alu(input logic [1:0] alt, input logic [5:0] funct,
                             input logic [31:0] a, input logic [31:0] b);
        alt_ctrl_i2 = alt;
        funct_i6    = funct;
        a_i32       = a;
        b_i32       = b;
    endtask

    task automatic pop_alu_out(input string name);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, got 0x%08h expected an entry", name, alu_out_o32);
        end else begin
            exp = sb_q.pop_front();
            check(name, alu_out_o32, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{2'b00, 6'b000000, 32'd5,        32'd7,        32'd12,       1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 32'h1234,     32'h1234,     32'd0,        1'b1};
        vecs[2]  = '{2'b10, 6'b100010, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[4]  = '{2'b10, 6'b101010, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[5]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[6]  = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
        vecs[7]  = '{2'b10, 6'b000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b1};
        vecs[8]  = '{2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[9]  = '{2'b11, 6'b100100, 32'd2,        32'd3,        32'd5,        1'b0};
        vecs[10] = '{2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0};
        vecs[11] = '{2'b10, 6'b101010, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[12] = '{2'b01, 6'b100101, 32'd10,       32'd4,        32'd6,        1'b0};
        vecs[13] = '{2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1};

        reset_i = 1'b0;
        en_i    = 1'b1;
        d_i32   = 32'hA5A5A5A5;
        drive_alu(2'b00, 6'd0, 32'd9, 32'd9);
        #3;
        check("reset_q", q_o32, 32'd0);
        check("reset_alu_out", alu_out_o32, 32'd0);
        check("reset_y_live", y_o32, 32'd18);
        @(posedge clk_i);
        #1;
        check("reset_hold_q", q_o32, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        en_i    = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive_alu(vecs[i].alt, vecs[i].funct, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("y[%0d]", i), y_o32, vecs[i].exp_y);
            check($sformatf("zero[%0d]", i), {31'd0, zero_o}, {31'd0, vecs[i].exp_zero});
            sb_q.push_back(vecs[i].exp_y);
            @(posedge clk_i);
            #1;
            pop_alu_out($sformatf("alu_out[%0d]", i));
        end

        en_i  = 1'b1;
        d_i32 = 32'hDEADBEEF;
        @(posedge clk_i);
        #1;
        check("q_load", q_o32, 32'hDEADBEEF);
        en_i  = 1'b0;
        d_i32 = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
        end
        check("q_hold", q_o32, 32'hDEADBEEF);

        drive_alu(2'b00, 6'd0, 32'd5, 32'd7);
        sb_q.push_back(32'd12);
        @(posedge clk_i);
        #1;
        pop_alu_out("alu_out_pre_reset");

        #2;
        reset_i = 1'b0;
        en_i    = 1'b1;
        d_i32   = 32'h55AA55AA;
        #1;
        check("mid_reset_q", q_o32, 32'd0);
        check("mid_reset_alu_out", alu_out_o32, 32'd0);
        check("mid_reset_y", y_o32, 32'd12);
        @(posedge clk_i);
        #1;
        check("held_reset_q", q_o32, 32'd0);
        check("held_reset_alu_out", alu_out_o32, 32'd0);

        @(negedge clk_i);
        reset_i = 1'b1;
        en_i    = 1'b1;
        d_i32   = 32'hCAFEF00D;
        sb_q.push_back(32'd12);
        @(posedge clk_i);
        #1;
        check("release_q", q_o32, 32'hCAFEF00D);
        pop_alu_out("release_alu_out");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
